// File: rtl/mer_meas_pkg.sv
// Shared types and constants for the MER measurement sequencer.
package mer_meas_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        ACCUM  = 2'd2,
        DONE   = 2'd3
    } state_t;

    localparam state_t      STATE_RST        = IDLE;
    localparam logic        FLAG_RST         = 1'b0;
    localparam int unsigned SETTLE_CNT_WIDTH = 8;

    // Window sums of 2^log2_syms full-scale squares never overflow this width.
    function automatic int unsigned acc_width(input int unsigned data_width,
                                              input int unsigned log2_syms);
        return 2 * data_width + log2_syms;
    endfunction

endpackage

// File: rtl/mer_meas_ctrl_if.sv
// Sample/control/result bundle between the channel-model side and the MER sequencer.
interface mer_meas_ctrl_if
    import mer_meas_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 18,
    parameter int unsigned ACC_WIDTH  = acc_width(18, 16)
);
    logic                         clk_en;
    logic                         start;
    logic                         abort;
    logic signed [DATA_WIDTH-1:0] error;
    logic signed [DATA_WIDTH-1:0] errorless;
    logic                         busy;
    logic                         done;
    logic [ACC_WIDTH-1:0]         err_power;
    logic [ACC_WIDTH-1:0]         sig_power;

    modport master (
        output clk_en, start, abort, error, errorless,
        input  busy, done, err_power, sig_power
    );

    modport slave (
        input  clk_en, start, abort, error, errorless,
        output busy, done, err_power, sig_power
    );

endinterface

// File: rtl/mer_sq_acc.sv
// Signed square-and-accumulate; acc_nxt_c exposes the running sum including the current sample.
module mer_sq_acc
    import mer_meas_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 18,
    parameter int unsigned ACC_WIDTH  = acc_width(18, 16)
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         clear,
    input  logic                         en,
    input  logic signed [DATA_WIDTH-1:0] din,
    output logic [ACC_WIDTH-1:0]         acc_nxt_c
);
    localparam int unsigned SQ_WIDTH = 2 * DATA_WIDTH;

    logic signed [SQ_WIDTH-1:0] sq_c;
    logic [ACC_WIDTH-1:0]       acc_q;

    // Full-precision square: (-2^(DW-1))^2 still fits the 2*DW unsigned view.
    always_comb begin
        sq_c      = SQ_WIDTH'(din) * SQ_WIDTH'(din);
        acc_nxt_c = acc_q + ACC_WIDTH'($unsigned(sq_c));
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            acc_q <= '0;
        end else if (clear) begin
            acc_q <= '0;
        end else if (en) begin
            acc_q <= acc_nxt_c;
        end
    end

endmodule

// File: rtl/mer_meas_ctrl.sv
// MER measurement sequencer: settle, accumulate error/signal power over 2^LOG2_SYMS symbols, publish.
module mer_meas_ctrl
    import mer_meas_pkg::*;
#(
    parameter int unsigned DATA_WIDTH  = 18,
    parameter int unsigned LOG2_SYMS   = 16,
    parameter int unsigned SETTLE_SYMS = 4
) (
    input  logic           clk,
    input  logic           reset,
    mer_meas_ctrl_if.slave bus
);
    localparam int unsigned    ACC_WIDTH   = acc_width(DATA_WIDTH, LOG2_SYMS);
    localparam int unsigned    SCW         = SETTLE_CNT_WIDTH;
    localparam logic [SCW-1:0] SETTLE_LAST = SCW'((SETTLE_SYMS == 0) ? 0 : SETTLE_SYMS - 1);

    state_t                 state_q;
    state_t                 state_nxt;
    logic [SCW-1:0]         settle_cnt_q;
    logic [LOG2_SYMS-1:0]   sym_cnt_q;

    logic                   start_ok_c;
    logic                   settle_last_c;
    logic                   sym_last_c;
    logic                   acc_clear_c;
    logic                   acc_en_c;
    logic                   settle_inc_c;
    logic                   sym_inc_c;
    logic                   load_c;
    logic                   busy_nxt_c;
    logic                   done_nxt_c;
    logic [ACC_WIDTH-1:0]   err_nxt_c;
    logic [ACC_WIDTH-1:0]   sig_nxt_c;

    assign start_ok_c    = (state_q == IDLE) && bus.start && !bus.abort;
    assign settle_last_c = (settle_cnt_q == SETTLE_LAST);
    assign sym_last_c    = &sym_cnt_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= STATE_RST;
        end else begin
            state_q <= state_nxt;
        end
    end

    // Abort takes priority over enable-driven progress in every busy state except DONE.
    always_comb begin
        state_nxt = state_q;
        case (state_q)
            IDLE: begin
                if (start_ok_c) begin
                    state_nxt = (SETTLE_SYMS == 0) ? ACCUM : SETTLE;
                end
            end
            SETTLE: begin
                if (bus.abort) begin
                    state_nxt = IDLE;
                end else if (bus.clk_en && settle_last_c) begin
                    state_nxt = ACCUM;
                end
            end
            ACCUM: begin
                if (bus.abort) begin
                    state_nxt = IDLE;
                end else if (bus.clk_en && sym_last_c) begin
                    state_nxt = DONE;
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        acc_clear_c  = 1'b0;
        acc_en_c     = 1'b0;
        settle_inc_c = 1'b0;
        sym_inc_c    = 1'b0;
        load_c       = 1'b0;
        busy_nxt_c   = (state_nxt != IDLE);
        done_nxt_c   = (state_nxt == DONE);
        case (state_q)
            IDLE:   acc_clear_c  = start_ok_c;
            SETTLE: settle_inc_c = bus.clk_en && !bus.abort;
            ACCUM: begin
                acc_en_c  = bus.clk_en && !bus.abort;
                sym_inc_c = acc_en_c;
                load_c    = acc_en_c && sym_last_c;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            settle_cnt_q <= '0;
            sym_cnt_q    <= '0;
        end else if (acc_clear_c) begin
            settle_cnt_q <= '0;
            sym_cnt_q    <= '0;
        end else begin
            if (settle_inc_c) settle_cnt_q <= settle_cnt_q + SCW'(1);
            if (sym_inc_c)    sym_cnt_q    <= sym_cnt_q + LOG2_SYMS'(1);
        end
    end

    mer_sq_acc #(
        .DATA_WIDTH (DATA_WIDTH),
        .ACC_WIDTH  (ACC_WIDTH)
    ) u_err_acc (
        .clk       (clk),
        .reset     (reset),
        .clear     (acc_clear_c),
        .en        (acc_en_c),
        .din       (bus.error),
        .acc_nxt_c (err_nxt_c)
    );

    mer_sq_acc #(
        .DATA_WIDTH (DATA_WIDTH),
        .ACC_WIDTH  (ACC_WIDTH)
    ) u_sig_acc (
        .clk       (clk),
        .reset     (reset),
        .clear     (acc_clear_c),
        .en        (acc_en_c),
        .din       (bus.errorless),
        .acc_nxt_c (sig_nxt_c)
    );

    // Results load from the sum that includes the final sample, so they are valid alongside done.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            bus.busy      <= FLAG_RST;
            bus.done      <= FLAG_RST;
            bus.err_power <= '0;
            bus.sig_power <= '0;
        end else begin
            bus.busy <= busy_nxt_c;
            bus.done <= done_nxt_c;
            if (load_c) begin
                bus.err_power <= err_nxt_c;
                bus.sig_power <= sig_nxt_c;
            end
        end
    end

endmodule

// File: tb/tb_mer_meas_ctrl.sv
// Bench for mer_meas_ctrl: two instances (settle 2 and settle 0) share stimulus, each checked every clk.
module tb_mer_meas_ctrl;
    import mer_meas_pkg::*;

    localparam int unsigned DW  = 18;
    localparam int unsigned L2  = 4;
    localparam int          WIN = 16;
    localparam int unsigned AW  = acc_width(DW, L2);

    logic clk;
    logic reset;

    mer_meas_ctrl_if #(.DATA_WIDTH(DW), .ACC_WIDTH(AW)) ia ();
    mer_meas_ctrl_if #(.DATA_WIDTH(DW), .ACC_WIDTH(AW)) ib ();

    mer_meas_ctrl #(.DATA_WIDTH(DW), .LOG2_SYMS(L2), .SETTLE_SYMS(2)) u_dut_a (
        .clk   (clk),
        .reset (reset),
        .bus   (ia)
    );

    mer_meas_ctrl #(.DATA_WIDTH(DW), .LOG2_SYMS(L2), .SETTLE_SYMS(0)) u_dut_b (
        .clk   (clk),
        .reset (reset),
        .bus   (ib)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks;
    int n_errors;
    int ph;
    int en_total;
    int mode;
    int ramp;
    logic signed [DW-1:0] c_err, c_sig, d_err, d_sig;

    // Reference model: counts enables since start instead of tracking controller states.
    int     settle_m [2] = '{2, 0};
    int     ph_m     [2];
    int     n_m      [2];
    longint acc_e    [2];
    longint acc_s    [2];
    longint out_e    [2];
    longint out_s    [2];
    int     done_cnt [2];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0d exp=%0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic signed [DW-1:0] rand_sample();
        logic signed [DW-1:0] r;
        r = DW'($urandom);
        case ($urandom_range(0, 7))
            0: r = {1'b1, {(DW-1){1'b0}}};
            1: r = {1'b0, {(DW-1){1'b1}}};
            default: ;
        endcase
        return r;
    endfunction

    function automatic void model_edge(input int i, input bit st, input bit ab, input bit en);
        longint e, s;
        e = longint'(d_err);
        s = longint'(d_sig);
        case (ph_m[i])
            0: if (st && !ab) begin
                ph_m[i]  = 1;
                n_m[i]   = 0;
                acc_e[i] = 0;
                acc_s[i] = 0;
            end
            1: if (ab) begin
                ph_m[i] = 0;
            end else if (en) begin
                n_m[i]++;
                if (n_m[i] > settle_m[i]) begin
                    acc_e[i] += e * e;
                    acc_s[i] += s * s;
                end
                if (n_m[i] == settle_m[i] + WIN) begin
                    out_e[i] = acc_e[i];
                    out_s[i] = acc_s[i];
                    ph_m[i]  = 2;
                end
            end
            default: ph_m[i] = 0;
        endcase
    endfunction

    task automatic check_outputs();
        check("a_busy", 64'(ia.busy), 64'(ph_m[0] != 0));
        check("a_done", 64'(ia.done), 64'(ph_m[0] == 2));
        check("a_err",  64'(ia.err_power), out_e[0]);
        check("a_sig",  64'(ia.sig_power), out_s[0]);
        check("b_busy", 64'(ib.busy), 64'(ph_m[1] != 0));
        check("b_done", 64'(ib.done), 64'(ph_m[1] == 2));
        check("b_err",  64'(ib.err_power), out_e[1]);
        check("b_sig",  64'(ib.sig_power), out_s[1]);
        if (ia.done) done_cnt[0]++;
        if (ib.done) done_cnt[1]++;
    endtask

    // One clk: drive inputs, advance the model over the coming edge, then sample 1 time unit after it.
    task automatic step(input bit st, input bit ab);
        bit en;
        ph = (ph + 1) % 16;
        en = (ph == 0);
        if (en) begin
            en_total++;
            case (mode)
                0: begin d_err = rand_sample(); d_sig = rand_sample(); end
                1: begin d_err = c_err; d_sig = c_sig; end
                default: begin d_err = DW'(ramp); d_sig = -DW'(ramp); ramp++; end
            endcase
        end
        ia.clk_en = en;  ib.clk_en = en;
        ia.start  = st;  ib.start  = st;
        ia.abort  = ab;  ib.abort  = ab;
        ia.error  = d_err; ib.error = d_err;
        ia.errorless = d_sig; ib.errorless = d_sig;
        for (int i = 0; i < 2; i++) model_edge(i, st, ab, en);
        @(posedge clk);
        #1;
        check_outputs();
    endtask

    task automatic run_until_idle(input int max_cyc);
        int k;
        bit timed_out;
        k = 0;
        while ((ph_m[0] != 0 || ph_m[1] != 0) && k < max_cyc) begin
            step(1'b0, 1'b0);
            k++;
        end
        timed_out = (ph_m[0] != 0 || ph_m[1] != 0);
        check("idle_bound", 64'(timed_out), 64'(0));
    endtask

    task automatic align_to_enable();
        while (ph != 15) step(1'b0, 1'b0);
    endtask

    task automatic run_enables(input int n);
        int target;
        target = en_total + n;
        while (en_total < target) step(1'b0, 1'b0);
    endtask

    initial begin
        n_checks = 0; n_errors = 0; ph = 0; en_total = 0; mode = 0; ramp = 0;
        c_err = '0; c_sig = '0; d_err = '0; d_sig = '0;
        for (int i = 0; i < 2; i++) begin
            ph_m[i] = 0; n_m[i] = 0; acc_e[i] = 0; acc_s[i] = 0;
            out_e[i] = 0; out_s[i] = 0; done_cnt[i] = 0;
        end
        ia.clk_en = 1'b0; ia.start = 1'b0; ia.abort = 1'b0; ia.error = '0; ia.errorless = '0;
        ib.clk_en = 1'b0; ib.start = 1'b0; ib.abort = 1'b0; ib.error = '0; ib.errorless = '0;
        reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_a_busy", 64'(ia.busy), 64'(0));
        check("rst_a_done", 64'(ia.done), 64'(0));
        check("rst_a_err",  64'(ia.err_power), 64'(0));
        check("rst_b_sig",  64'(ib.sig_power), 64'(0));
        reset = 1'b1;
        step(1'b0, 1'b0);

        // Constant small-amplitude window.
        mode = 1; c_err = 18'sd100; c_sig = 18'sd1000;
        done_cnt = '{0, 0};
        step(1'b1, 1'b0);
        run_until_idle(1000);
        check("s1_a_err",  64'(ia.err_power), 64'd160000);
        check("s1_a_sig",  64'(ia.sig_power), 64'd16000000);
        check("s1_b_err",  64'(ib.err_power), 64'd160000);
        check("s1_a_ndone", 64'(done_cnt[0]), 64'd1);
        step(1'b0, 1'b0);

        // Full-scale samples: most negative error, most positive errorless.
        c_err = -18'sd131072; c_sig = 18'sd131071;
        step(1'b1, 1'b0);
        run_until_idle(1000);
        check("s2_a_err", 64'(ia.err_power), 64'd274877906944);
        check("s2_a_sig", 64'(ia.sig_power), 64'd274873712656);
        step(1'b0, 1'b0);

        // Extra starts while busy must be ignored.
        c_err = 18'sd100; c_sig = 18'sd1000;
        done_cnt = '{0, 0};
        align_to_enable();
        step(1'b1, 1'b0);
        repeat (19) step(1'b0, 1'b0);
        step(1'b1, 1'b0);
        repeat (80) step(1'b0, 1'b0);
        step(1'b1, 1'b0);
        run_until_idle(1000);
        check("s3_a_ndone", 64'(done_cnt[0]), 64'd1);
        check("s3_b_ndone", 64'(done_cnt[1]), 64'd1);
        check("s3_a_err",   64'(ia.err_power), 64'd160000);
        check("s3_a_sig",   64'(ia.sig_power), 64'd16000000);

        // Abort after five accumulated symbols, then a fresh random window.
        mode = 0;
        done_cnt = '{0, 0};
        align_to_enable();
        step(1'b1, 1'b0);
        run_enables(7);
        step(1'b0, 1'b1);
        check("ab_a_busy", 64'(ia.busy), 64'(0));
        check("ab_a_err",  64'(ia.err_power), 64'd160000);
        step(1'b0, 1'b0);
        check("ab_a_ndone", 64'(done_cnt[0]), 64'd0);
        step(1'b1, 1'b0);
        run_until_idle(1000);
        step(1'b0, 1'b0);

        // Start on an enable with a ramp 1,2,3... from the next enable.
        align_to_enable();
        mode = 1; c_err = 18'sd5000; c_sig = 18'sd3000;
        step(1'b1, 1'b0);
        mode = 2; ramp = 1;
        run_until_idle(1000);
        check("ramp_b_err", 64'(ib.err_power), 64'd1496);
        check("ramp_b_sig", 64'(ib.sig_power), 64'd1496);
        check("ramp_a_err", 64'(ia.err_power), 64'd2104);
        step(1'b0, 1'b0);

        // Asynchronous reset in the middle of accumulation.
        mode = 0;
        step(1'b1, 1'b0);
        run_enables(5);
        reset = 1'b0;
        #1;
        check("ar_a_busy", 64'(ia.busy), 64'(0));
        check("ar_a_done", 64'(ia.done), 64'(0));
        check("ar_a_err",  64'(ia.err_power), 64'(0));
        check("ar_a_sig",  64'(ia.sig_power), 64'(0));
        check("ar_b_err",  64'(ib.err_power), 64'(0));
        for (int i = 0; i < 2; i++) begin
            ph_m[i] = 0; out_e[i] = 0; out_s[i] = 0;
        end
        reset = 1'b1;

        // Random windows and random start/abort traffic.
        repeat (3) begin
            step(1'b1, 1'b0);
            run_until_idle(1000);
            step(1'b0, 1'b0);
        end
        repeat (1500) step($urandom_range(0, 15) == 0, $urandom_range(0, 63) == 0);
        run_until_idle(1000);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
